// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce_bank button conditioner.
// Holds the counter width function, the released level and parameter floors.
package debounce_pkg;

  // Level a channel rests at after reset: not pressed.
  localparam logic RELEASED = 1'b0;

  // Smallest legal values for the bank parameters.
  localparam int MIN_COUNTER_MAX = 2;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MIN_HOLD_MAX    = 1;

  // Bits needed to hold the values 0 .. value-1 (never less than 1).
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_bank_channel.sv
// One debounce channel: input synchroniser, stable-time filter, hold timer.
// Ports: clk, rst (async, active-high), noisy_i (raw input), clean_o (level),
// rise_o / fall_o / long_o (1-cycle pulses), event_o (rise or fall next edge).
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int COUNTER_MAX = 128,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_MAX    = 4096,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o,
  output logic event_o
);

  localparam int CW = clog2(COUNTER_MAX + 1);
  localparam int HW = clog2(HOLD_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(COUNTER_MAX - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);
  localparam logic          POL       = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [HW-1:0]          hold_q;
  logic [HW-1:0]          hold_d;
  logic                   clean_q;
  logic                   clean_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;
  logic                   long_q;
  logic                   long_d;

  logic s;
  logic differ;
  logic expire;

  // Polarity is folded in before the first flop so that the whole
  // chain, and everything after it, works in "1 = pressed" terms.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], noisy_i ^ POL};
  assign s      = sync_q[SYNC_STAGES-1];

  assign differ = (s != clean_q);
  assign expire = differ && (cnt_q == CNT_LAST);

  // Stable-time filter: any cycle that agrees with the clean level
  // throws away the partial count.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (!differ || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (expire) begin
      clean_d = s;
    end
  end

  always_comb begin
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (expire) begin
      rise_d = s;
      fall_d = !s;
    end
  end

  // Hold timer saturates so a long press fires exactly once; a release
  // landing on the same edge as the would-be long press suppresses it.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!clean_q || fall_d) begin
      hold_d = '0;
    end else if (hold_q != HOLD_SAT) begin
      hold_d = hold_q + HW'(1);
    end
    if (clean_q && !fall_d && (hold_q == HOLD_LAST)) begin
      long_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RELEASED}};
      cnt_q   <= '0;
      hold_q  <= '0;
      clean_q <= RELEASED;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign long_o  = long_q;
  assign event_o = rise_d | fall_d;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button conditioner: N_CH independent debounce channels.
// Ports: clk, rst (async, active-high), noisy_in[N_CH] raw buttons;
// clean_out, rise_pulse, fall_pulse, long_pulse per channel; any_event.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int COUNTER_MAX = 128,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_MAX    = 4096,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic            any_event
);

  if (COUNTER_MAX < MIN_COUNTER_MAX) begin : g_bad_counter_max
    $error("debounce_bank: COUNTER_MAX must be at least 2");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("debounce_bank: SYNC_STAGES must be at least 2");
  end
  if (HOLD_MAX < MIN_HOLD_MAX) begin : g_bad_hold_max
    $error("debounce_bank: HOLD_MAX must be at least 1");
  end

  logic [N_CH-1:0] evt_w;
  logic            any_q;
  logic            any_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .COUNTER_MAX (COUNTER_MAX),
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_MAX    (HOLD_MAX),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .noisy_i (noisy_in[g]),
      .clean_o (clean_out[g]),
      .rise_o  (rise_pulse[g]),
      .fall_o  (fall_pulse[g]),
      .long_o  (long_pulse[g]),
      .event_o (evt_w[g])
    );
  end

  // Built from the channels' next-state events so that it lands in
  // the same cycle as the pulses it summarises.
  assign any_d = |evt_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign any_event = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: an active-high and an active-low
// instance share the inputs and are compared against a timeline model.
module tb_debounce_bank;

  localparam int N  = 4;
  localparam int CM = 8;
  localparam int SS = 2;
  localparam int HM = 32;

  logic         clk;
  logic         rst;
  logic [N-1:0] noisy_in;

  logic [N-1:0] clean_out, rise_pulse, fall_pulse, long_pulse;
  logic         any_event;
  logic [N-1:0] clean_lo, rise_lo, fall_lo, long_lo;
  logic         any_lo;

  debounce_bank #(
    .N_CH(N), .COUNTER_MAX(CM), .SYNC_STAGES(SS),
    .HOLD_MAX(HM), .ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .rst(rst), .noisy_in(noisy_in),
    .clean_out(clean_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .long_pulse(long_pulse),
    .any_event(any_event)
  );

  debounce_bank #(
    .N_CH(N), .COUNTER_MAX(CM), .SYNC_STAGES(SS),
    .HOLD_MAX(HM), .ACTIVE_LOW(1)
  ) u_dut_lo (
    .clk(clk), .rst(rst), .noisy_in(noisy_in),
    .clean_out(clean_lo), .rise_pulse(rise_lo),
    .fall_pulse(fall_lo), .long_pulse(long_lo),
    .any_event(any_lo)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int vec;
  int bad;

  // Timeline model: hist[e] is the raw input at edge e since reset
  // release; the synchronised value seen at edge e is hist[e-SS].
  logic [N-1:0] hist[$];
  int           k;
  bit           m_clean[2][N];
  bit           m_rise[2][N];
  bit           m_fall[2][N];
  bit           m_long[2][N];
  int           last_chg[2][N];
  int           rise_e[2][N];

  function automatic bit s_at(int inst, int c, int e);
    logic [N-1:0] v;
    if (e < SS) return 1'b0;
    v = hist[e-SS];
    return v[c] ^ (inst == 1);
  endfunction

  task automatic model_reset();
    hist.delete();
    k = 0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < N; c++) begin
        m_clean[i][c] = 0; m_rise[i][c] = 0;
        m_fall[i][c]  = 0; m_long[i][c] = 0;
        last_chg[i][c] = -1; rise_e[i][c] = -100000;
      end
  endtask

  // Level flips once the last CM synchronised samples, all taken after
  // the previous flip, disagree with it.  Long press is due HM edges
  // after the rise edge unless the level drops on that very edge.
  task automatic model_edge(input logic [N-1:0] v);
    hist.push_back(v);
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < N; c++) begin
        bit flip;
        bit held;
        flip = 1;
        for (int j = 0; j < CM; j++) begin
          int e;
          e = k - j;
          if (e < 0 || e <= last_chg[i][c]) flip = 0;
          else if (s_at(i, c, e) == m_clean[i][c]) flip = 0;
        end
        held = m_clean[i][c] && (k - rise_e[i][c] == HM);
        m_rise[i][c] = flip && !m_clean[i][c];
        m_fall[i][c] = flip && m_clean[i][c];
        m_long[i][c] = held && !flip;
        if (flip) begin
          m_clean[i][c] = !m_clean[i][c];
          last_chg[i][c] = k;
          if (m_clean[i][c]) rise_e[i][c] = k;
        end
      end
    k++;
  endtask

  function automatic logic [16:0] exp_inst(int i);
    logic [N-1:0] c, r, f, l;
    for (int ch = 0; ch < N; ch++) begin
      c[ch] = m_clean[i][ch]; r[ch] = m_rise[i][ch];
      f[ch] = m_fall[i][ch];  l[ch] = m_long[i][ch];
    end
    return {c, r, f, l, |(r | f)};
  endfunction

  function automatic logic [33:0] exp_vec();
    return {exp_inst(0), exp_inst(1)};
  endfunction

  function automatic logic [33:0] dut_vec();
    return {clean_out, rise_pulse, fall_pulse, long_pulse, any_event,
            clean_lo, rise_lo, fall_lo, long_lo, any_lo};
  endfunction

  task automatic tick(input logic [N-1:0] v);
    noisy_in = v;
    @(posedge clk);
    if (!rst) model_edge(v);
    #1;
  endtask

  task automatic test_reset();
    int rise_at, any_n;
    rise_at = -1; any_n = 0;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(4'hF);
      vec++;
      if (dut_vec() !== 34'd0) begin
        bad++; $display("FAIL reset_hold got=%h want=0", dut_vec());
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(4'hF);
      vec++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL reset_model e=%0d got=%h want=%h", k-1, dut_vec(), exp_vec());
      end
      if (rise_pulse === 4'hF) rise_at = k - 1;
      if (any_event === 1'b1) any_n++;
    end
    vec++;
    if (rise_at != SS + CM - 1) begin
      bad++; $display("FAIL reset_latency got=%0d want=%0d", rise_at, SS+CM-1);
    end
    vec++;
    if (any_n != 1) begin
      bad++; $display("FAIL reset_any_event got=%0d want=1", any_n);
    end
  endtask

  task automatic test_bounce();
    int rises, rise_at, kstart;
    rises = 0; rise_at = -1;
    for (int i = 0; i < 14; i++) begin
      tick(4'h0);
      vec++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL bounce_settle got=%h want=%h", dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 36; i++) begin
      if (i == 20) kstart = k;
      tick((i < 20 && (i % 4) == 3) ? 4'h0 : 4'h1);
      vec++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL bounce_model e=%0d got=%h want=%h", k-1, dut_vec(), exp_vec());
      end
      if (rise_pulse[0] === 1'b1) begin rises++; rise_at = k - 1; end
    end
    vec++;
    if (rises != 1) begin
      bad++; $display("FAIL bounce_rise_count got=%0d want=1", rises);
    end
    vec++;
    if (rise_at != kstart + SS + CM - 1) begin
      bad++; $display("FAIL bounce_latency got=%0d want=%0d", rise_at, kstart+SS+CM-1);
    end
  endtask

  // Three presses on ch1: short (20), long (40), and one whose release
  // lands exactly on the edge the long press would fire.
  task automatic test_long_press();
    for (int i = 0; i < 14; i++) tick(4'h0);
    model_reset_check: for (int p = 0; p < 3; p++) begin
      int hold, r, fall_n, fall_at, long_n, long_at;
      hold = (p == 0) ? 20 : (p == 1) ? 40 : 22;
      r = -1; fall_n = 0; fall_at = -1; long_n = 0; long_at = -1;
      for (int i = 0; i < 70; i++) begin
        tick((r < 0 || k <= r + hold) ? 4'b0010 : 4'b0000);
        vec++;
        if (dut_vec() !== exp_vec()) begin
          bad++;
          $display("FAIL long_model p=%0d e=%0d got=%h want=%h", p, k-1, dut_vec(), exp_vec());
        end
        if (rise_pulse[1] === 1'b1 && r < 0) r = k - 1;
        if (fall_pulse[1] === 1'b1) begin fall_n++; fall_at = k - 1; end
        if (long_pulse[1] === 1'b1) begin long_n++; long_at = k - 1; end
      end
      vec++;
      if (r < 0) begin
        bad++; $display("FAIL long_no_rise p=%0d got=none want=rise", p);
      end
      vec++;
      if (fall_n != 1) begin
        bad++; $display("FAIL long_fall_count p=%0d got=%0d want=1", p, fall_n);
      end
      vec++;
      if (long_n != ((p == 1) ? 1 : 0)) begin
        bad++; $display("FAIL long_count p=%0d got=%0d want=%0d", p, long_n, (p == 1) ? 1 : 0);
      end
      if (p == 1) begin
        vec++;
        if (long_at != r + HM) begin
          bad++; $display("FAIL long_timing got=%0d want=%0d", long_at, r + HM);
        end
      end
      if (p == 2) begin
        vec++;
        if (fall_at != r + HM) begin
          bad++; $display("FAIL long_fall_wins got=%0d want=%0d", fall_at, r + HM);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int any_n, at, others, k0;
    logic [N-1:0] rp;
    any_n = 0; at = -1; others = 0; rp = '0; k0 = k;
    for (int i = 0; i < 14; i++) begin
      tick(4'b1001);
      vec++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL simul_model e=%0d got=%h want=%h", k-1, dut_vec(), exp_vec());
      end
      if (rise_pulse !== 4'b0000) begin rp = rise_pulse; at = k - 1; end
      if (any_event === 1'b1) any_n++;
      if (((rise_pulse | fall_pulse) & 4'b0110) !== 4'b0000) others++;
    end
    vec++;
    if (rp !== 4'b1001 || at != k0 + SS + CM - 1) begin
      bad++; $display("FAIL simul_rise got=%b@%0d want=1001@%0d", rp, at, k0+SS+CM-1);
    end
    vec++;
    if (any_n != 1) begin
      bad++; $display("FAIL simul_any got=%0d want=1", any_n);
    end
    vec++;
    if (others != 0) begin
      bad++; $display("FAIL simul_others got=%0d want=0", others);
    end
  endtask

  task automatic test_reset_mid();
    int r, early, rise_at;
    r = -1; early = 0; rise_at = -1;
    for (int i = 0; i < 14; i++) tick(4'h0);
    for (int i = 0; i < 16 && r < 0; i++) begin
      tick(4'b1000);
      if (rise_pulse[3] === 1'b1) r = k - 1;
    end
    vec++;
    if (r < 0) begin
      bad++; $display("FAIL mid_no_rise got=none want=rise");
      r = k;
    end
    // Release at r+14 so that by edge r+20 the hold count is 20 and
    // the debounce count has seen 5 low samples.
    while (k <= r + 20) begin
      tick((k <= r + 13) ? 4'b1000 : 4'b0000);
      vec++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL mid_model e=%0d got=%h want=%h", k-1, dut_vec(), exp_vec());
      end
    end
    vec++;
    if (clean_out[3] !== 1'b1) begin
      bad++; $display("FAIL mid_pre_level got=%b want=1", clean_out[3]);
    end
    #4 rst = 1'b1;
    #1;
    model_reset();
    vec++;
    if (dut_vec() !== 34'd0) begin
      bad++; $display("FAIL mid_async got=%h want=0", dut_vec());
    end
    for (int i = 0; i < 2; i++) tick(4'b1000);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(4'b1000);
      vec++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL mid_after e=%0d got=%h want=%h", k-1, dut_vec(), exp_vec());
      end
      if ((rise_pulse | fall_pulse | long_pulse) !== 4'b0000 && k - 1 < SS + CM - 1) early++;
      if (rise_pulse[3] === 1'b1) rise_at = k - 1;
    end
    vec++;
    if (early != 0 || rise_at != SS + CM - 1) begin
      bad++; $display("FAIL mid_restart got=%0d/%0d want=0/%0d", early, rise_at, SS+CM-1);
    end
  endtask

  task automatic test_active_low();
    int rise_at, fall_at, k0;
    rise_at = -1; fall_at = -1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) tick(4'h0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(4'h0);
      vec++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL alow_press e=%0d got=%h want=%h", k-1, dut_vec(), exp_vec());
      end
      if (rise_lo[2] === 1'b1) rise_at = k - 1;
    end
    vec++;
    if (rise_at != SS + CM - 1 || clean_lo[2] !== 1'b1) begin
      bad++; $display("FAIL alow_rise got=%0d/%b want=%0d/1", rise_at, clean_lo[2], SS+CM-1);
    end
    k0 = k;
    for (int i = 0; i < 14; i++) begin
      tick(4'b0100);
      vec++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL alow_release e=%0d got=%h want=%h", k-1, dut_vec(), exp_vec());
      end
      if (fall_lo[2] === 1'b1) fall_at = k - 1;
    end
    vec++;
    if (fall_at != k0 + SS + CM - 1) begin
      bad++; $display("FAIL alow_fall got=%0d want=%0d", fall_at, k0+SS+CM-1);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    int run[N];
    v = noisy_in;
    for (int c = 0; c < N; c++) run[c] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < N; c++) begin
        if (run[c] == 0) begin
          v[c] = $urandom_range(0, 1);
          run[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6)
                                               : $urandom_range(8, 45);
        end
        run[c]--;
      end
      tick(v);
      vec++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random e=%0d in=%b got=%h want=%h", k-1, v, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    vec = 0;
    bad = 0;
    rst = 1'b1;
    noisy_in = '1;
    model_reset();
    test_reset();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid();
    test_active_low();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
